// File: rtl/usb_tx_nrzi_encoder.sv
// NRZI line encoder and end-of-packet generator for the USB transmit path.
// Drives D+/D- from the stuffed bit stream; all bit activity advances on shift_strobe only.
module usb_tx_nrzi_encoder #(
    parameter int unsigned EOP_SE0_BITS = 2,
    parameter int unsigned EOP_J_BITS   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_strobe,
    input  logic       encoder_in,
    input  logic       tx_active,
    output logic       dplus,
    output logic       dminus,
    output logic       tx_busy,
    output logic       eop_done,
    output logic [1:0] fsm_state   // debug: 0=IDLE 1=DATA 2=EOP_SE0 3=EOP_J
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        EOP_SE0 = 2'd2,
        EOP_J   = 2'd3
    } state_t;

    localparam logic [2:0] SE0_LAST = 3'(EOP_SE0_BITS);
    localparam logic [2:0] J_LAST   = 3'(EOP_J_BITS);

    state_t     state, state_next;
    logic [2:0] cnt, cnt_next;
    logic       dplus_next, dminus_next, eop_done_next;

    assign fsm_state = state;

    // State register; line outputs and status flags are registered here too.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            dplus    <= 1'b1;
            dminus   <= 1'b0;
            tx_busy  <= 1'b0;
            eop_done <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            dplus    <= dplus_next;
            dminus   <= dminus_next;
            tx_busy  <= (state_next != IDLE);
            eop_done <= eop_done_next;
        end
    end

    // Next-state and bit-time counter.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (shift_strobe) begin
            case (state)
                IDLE: begin
                    if (tx_active) state_next = DATA;
                end
                DATA: begin
                    if (!tx_active) begin
                        state_next = EOP_SE0;
                        cnt_next   = 3'd1;
                    end
                end
                EOP_SE0: begin
                    if (cnt == SE0_LAST) begin
                        state_next = EOP_J;
                        cnt_next   = 3'd1;
                    end else begin
                        cnt_next = cnt + 3'd1;
                    end
                end
                EOP_J: begin
                    if (cnt == J_LAST) begin
                        state_next = IDLE;
                        cnt_next   = 3'd0;
                    end else begin
                        cnt_next = cnt + 3'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = 3'd0;
                end
            endcase
        end
    end

    // Line drive: in DATA the line is always J or K, so a 0 bit inverts both wires.
    always_comb begin
        dplus_next    = dplus;
        dminus_next   = dminus;
        eop_done_next = 1'b0;
        if (shift_strobe) begin
            case (state)
                IDLE: begin
                    dplus_next  = 1'b1;
                    dminus_next = 1'b0;
                    if (tx_active && !encoder_in) begin
                        dplus_next  = 1'b0;
                        dminus_next = 1'b1;
                    end
                end
                DATA: begin
                    if (tx_active) begin
                        if (!encoder_in) begin
                            dplus_next  = ~dplus;
                            dminus_next = ~dminus;
                        end
                    end else begin
                        dplus_next  = 1'b0;
                        dminus_next = 1'b0;
                    end
                end
                EOP_SE0: begin
                    dplus_next  = (cnt == SE0_LAST);
                    dminus_next = 1'b0;
                end
                EOP_J: begin
                    dplus_next    = 1'b1;
                    dminus_next   = 1'b0;
                    eop_done_next = (cnt == J_LAST);
                end
                default: begin
                    dplus_next  = 1'b1;
                    dminus_next = 1'b0;
                end
            endcase
        end
    end

endmodule
